// File: rtl/gray_ptr_rx.sv
// Receive side of the Gray-coded pointer crossing for the async FIFOs.
// Synchronises the foreign write pointer, decodes it to binary, owns the
// local read pointer and derives occupancy, empty/almost_empty and sticky
// integrity flags.
module gray_ptr_rx #(
  parameter int PTR_W       = 5,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PTR_W-1:0]   wptr_gray_in,
  input  logic               rd_en,
  output logic               rd_ok,
  output logic [PTR_W-2:0]   rd_addr,
  output logic [PTR_W-1:0]   rptr_bin,
  output logic [PTR_W-1:0]   rptr_gray,
  output logic [PTR_W-1:0]   count,
  output logic               empty,
  output logic               almost_empty,
  output logic               underflow,
  output logic               gray_err,
  output logic               count_err
);

  // Reflected binary to Gray.
  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_W-1:0] sync_q [SYNC_STAGES];
  logic [PTR_W-1:0] wsync_last;
  logic [PTR_W-1:0] wsync_prev;
  logic [PTR_W-1:0] wptr_bin_q;
  logic [PTR_W-1:0] gray_step;
  logic             multi_step;
  logic [PTR_W-1:0] rptr_inc;

  assign wsync_last = sync_q[SYNC_STAGES-1];

  // Plain flop chain on the foreign pointer; nothing may sit between stages.
  always_ff @(posedge clk) begin
    // NOTE: this array is a handful of synchroniser flops, so every entry is
    // reset; a real storage RAM would be left unreset so it maps to memory.
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wptr_gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Combinational status derived only from registers (plus rd_en for the pop strobes).
  always_comb begin
    // NOTE: every signal is assigned on every path through this block, so no
    // latch can be inferred; blocking '=' is correct in combinational logic.
    gray_step    = wsync_last ^ wsync_prev;
    // x & (x-1) clears the lowest set bit; nonzero means two or more bits moved.
    multi_step   = |(gray_step & (gray_step - PTR_W'(1)));
    count        = wptr_bin_q - rptr_bin;
    empty        = (count == '0);
    almost_empty = (count <= PTR_W'(AE_LEVEL));
    rd_ok        = rd_en && !empty;
    underflow    = rd_en && empty;
    rptr_inc     = rptr_bin + PTR_W'(1);
    rd_addr      = rptr_bin[PTR_W-2:0];
  end

  // Decode stage and sticky integrity flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      wptr_bin_q <= '0;
      wsync_prev <= '0;
      gray_err   <= 1'b0;
      count_err  <= 1'b0;
    end else begin
      wptr_bin_q <= gray2bin(wsync_last);
      wsync_prev <= wsync_last;
      if (multi_step) gray_err <= 1'b1;
      if (count > PTR_W'(DEPTH)) count_err <= 1'b1;
    end
  end

  // Local read pointer and its Gray copy for the write domain, advanced together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_bin  <= '0;
      rptr_gray <= '0;
    end else if (rd_ok) begin
      rptr_bin  <= rptr_inc;
      rptr_gray <= bin2gray(rptr_inc);
    end
  end

endmodule

// File: doc/gray_ptr_rx.md
Name: gray_ptr_rx

Overview:
- Receive side of the Gray-coded pointer crossing used by the team's async FIFOs.
- Takes the write pointer Gray code from the foreign clock domain and synchronises it into the local clock.
- Decodes it back to binary and owns the local read pointer.
- Produces empty, almost_empty, occupancy count, read address and Gray read pointer (for return to the write side), plus sticky integrity flags.

Parameters:
- PTR_W, 5, pointer width; address width + 1 wrap bit.
- DEPTH, 16, FIFO depth; must equal 2**(PTR_W-1).
- SYNC_STAGES, 2, synchroniser flop count; minimum 2.
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.

Ports:
- clk  input  1  local (read-domain) clock, all logic posedge.
- rst  input  1  synchronous reset, active-high.
- wptr_gray_in  input  PTR_W  write pointer, reflected Gray, foreign domain.
- rd_en  input  1  pop request.
- rd_ok  output  1  pop accepted this cycle (rd_en && !empty), combinational.
- rd_addr  output  PTR_W-1  memory read address = rptr_bin[PTR_W-2:0].
- rptr_bin  output  PTR_W  local binary read pointer.
- rptr_gray  output  PTR_W  registered Gray of rptr_bin, for the write domain.
- count  output  PTR_W  occupancy.
- empty  output  1  FIFO empty.
- almost_empty  output  1  count <= AE_LEVEL.
- underflow  output  1  one-cycle pulse: rd_en while empty.
- gray_err  output  1  sticky: synchronised pointer moved by more than one Gray step.
- count_err  output  1  sticky: count > DEPTH.

Behaviour:
- Gray code is standard reflected, g = b ^ (b >> 1). Decode: b[PTR_W-1] = g[PTR_W-1]; b[i] = b[i+1] ^ g[i].
- Synchroniser: SYNC_STAGES flops in series on wptr_gray_in, all reset to 0. No logic between stages.
- Decode stage: wptr_bin_q <= decode(last sync stage) and wsync_prev <= last sync stage, one register each, reset 0.
- Latency: a wptr_gray_in change is reflected in count/empty SYNC_STAGES+1 clk edges later.
- Read pointer: rptr_bin <= rptr_bin + 1 on rd_ok, wrapping mod 2**PTR_W (11111 -> 00000). rptr_gray <= gray(rptr_bin + 1) on the same edge, so it always equals gray(rptr_bin). Both reset to 0.
- count = (wptr_bin_q - rptr_bin) mod 2**PTR_W, combinational from registers only. No combinational path from wptr_gray_in.
- empty = (count == 0). almost_empty = (count <= AE_LEVEL).
- rd_ok and underflow depend on rd_en combinationally. rd_en while empty: pointer holds, underflow = 1 that cycle.
- Simultaneous pointer update and pop: both register updates take effect on the same edge. Next-cycle count = old wptr_bin_q decoded-new minus old rptr_bin minus 1; no special casing.
- gray_err: set when popcount(last sync stage ^ wsync_prev) > 1. Cleared only by rst.
- count_err: set when count > DEPTH. Cleared only by rst.
- Wrap bit: count is correct across the wrap because the subtraction is full PTR_W width. count == DEPTH is legal (full), not an error.
- Reset mid-operation: on the rst edge all registers go to 0 regardless of rd_en.
  - Outputs after reset: empty = 1, almost_empty = 1, count = 0, rd_addr = 0, rptr_bin = 0, rptr_gray = 0, rd_ok = 0 (empty), underflow = rd_en, gray_err = 0, count_err = 0.
  - The write side is reset by its own domain. A nonzero wptr_gray_in after reset is taken as a valid pointer.

Test Plan:
- Reset, hold wptr_gray_in = 0, pulse rd_en -> empty = 1, count = 0, underflow = 1 for the single pulse, rptr_bin stays 0.
- Step wptr_gray_in 00000 -> 00001 -> 00011 (bin 1, 2) one value per cycle -> count reaches 1 then 2 exactly SYNC_STAGES+1 = 3 edges after each change; almost_empty = 1 at count 2; gray_err = 0.
- Set wptr_gray_in = gray(16) = 11000 gradually, then pop 16 times with rd_en held:
  - rd_addr runs 0..15.
  - After the 16th pop, rptr_bin = 10000, rptr_gray = 11000, empty = 1.
  - A 17th rd_en gives underflow = 1.
- Wrap: preload rptr_bin = 30 via pops, wptr = bin 2 (gray 00011) -> count = 4; pops to rptr_bin = 31 then 0 -> rptr_gray 10000 then 00000, count 3 then 2.
- Integrity: jump wptr_gray_in 00000 -> 00110 in one cycle -> gray_err = 1 after 3 edges and stays 1. Jump to bin 20 with rptr_bin = 0 -> count = 20, count_err = 1. rst clears both.
- Pop and pointer advance on the same edge with count = 1 -> count stays 1, empty stays 0. Assert rst during a burst of pops -> all outputs at reset values the next cycle.
